// File: rtl/aq_mmu_jtlb_tag_bank.sv
// N-way JTLB tag storage bank: registered read port, per-set round-robin victim
// pointers and a hardware sequencer that clears every set on a flush request.

module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);
    logic clk_en_d;
    logic clk_en_q;

    assign clk_en_d = (global_en & (module_en | local_en)) | external_en | pad_yy_icg_scan_en;

    // Enable is captured while the clock is low so the gated clock never glitches.
    always_ff @(negedge clk_in) begin
        clk_en_q <= clk_en_d;
    end

    assign clk_out = clk_in & clk_en_q;
endmodule

module aq_mmu_jtlb_tag_bank #(
    parameter int WAYS  = 2,
    parameter int TAG_W = 48,
    parameter int IDX_W = 6,
    parameter int PTR_W = 1
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    cp0_mmu_icg_en,
    input  logic                    pad_yy_icg_scan_en,
    input  logic                    tag_req_vld,
    input  logic [IDX_W-1:0]        tag_req_idx,
    input  logic [WAYS-1:0]         tag_req_wen,
    input  logic [WAYS*TAG_W-1:0]   tag_req_din,
    input  logic                    tag_req_rpl_upd,
    output logic                    tag_req_rdy,
    output logic                    tag_rd_vld,
    output logic [WAYS*TAG_W-1:0]   tag_rd_dout,
    output logic [PTR_W-1:0]        tag_rd_victim,
    input  logic                    tag_flush_req,
    output logic                    tag_flush_busy,
    output logic                    tag_flush_done
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int DW    = WAYS * TAG_W;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_vld_q, rd_vld_d;
    logic [DW-1:0]      rd_dout_q, rd_dout_d;
    logic [PTR_W-1:0]   rd_victim_q, rd_victim_d;
    logic [PTR_W-1:0]   victim_q [DEPTH];
    logic [PTR_W-1:0]   victim_d [DEPTH];

    logic [DW-1:0]      tag_mem [DEPTH];

    logic               req_acc;
    logic               req_rd;
    logic               flush_act;
    logic               flush_last;
    logic [WAYS-1:0]    st_wen;
    logic [IDX_W-1:0]   st_idx;
    logic [DW-1:0]      st_din;
    logic               store_en;
    logic               store_clk;

    assign tag_req_rdy = (state_q == ST_IDLE) & ~tag_flush_req;
    assign req_acc     = tag_req_vld & tag_req_rdy;
    assign req_rd      = req_acc & ~(|tag_req_wen);
    assign flush_act   = (state_q == ST_FLUSH);
    assign flush_last  = flush_act & (cnt_q == {IDX_W{1'b1}});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (tag_flush_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_FLUSH);
        done_d = flush_last;
    end

    // Pointer width equals log2(WAYS), so the natural wrap is the round-robin modulo.
    always_comb begin
        victim_d = victim_q;
        if (flush_act) begin
            victim_d[cnt_q] = '0;
        end else if (req_acc && tag_req_rpl_upd) begin
            victim_d[tag_req_idx] = victim_q[tag_req_idx] + 1'b1;
        end
    end

    always_comb begin
        rd_vld_d    = req_rd;
        rd_dout_d   = rd_dout_q;
        rd_victim_d = rd_victim_q;
        if (req_rd) begin
            rd_dout_d   = tag_mem[tag_req_idx];
            rd_victim_d = victim_q[tag_req_idx];
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_dout_q   <= '0;
            rd_victim_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                victim_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_vld_q    <= rd_vld_d;
            rd_dout_q   <= rd_dout_d;
            rd_victim_q <= rd_victim_d;
            victim_q    <= victim_d;
        end
    end

    assign tag_flush_busy = busy_q;
    assign tag_flush_done = done_q;
    assign tag_rd_vld     = rd_vld_q;
    assign tag_rd_dout    = rd_dout_q;
    assign tag_rd_victim  = rd_victim_q;

    // The flush sequencer owns the store port; requests cannot be accepted meanwhile.
    always_comb begin
        st_wen = '0;
        st_idx = tag_req_idx;
        st_din = tag_req_din;
        if (flush_act) begin
            st_wen = '1;
            st_idx = cnt_q;
            st_din = '0;
        end else if (req_acc) begin
            st_wen = tag_req_wen;
        end
    end

    assign store_en = req_acc | flush_act;

    gated_clk_cell u_store_gate (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (cp0_mmu_icg_en),
        .local_en           (store_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (store_clk)
    );

    always_ff @(posedge store_clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (st_wen[w]) begin
                tag_mem[st_idx][w*TAG_W +: TAG_W] <= st_din[w*TAG_W +: TAG_W];
            end
        end
    end
endmodule
